dcache: RTL

// - Direct-mapped, write-through, no-write-allocate data cache between the MEM pipeline stage and backing data memory.
// - Load hits return data in the same cycle. Misses and all stores stall the pipeline through StallM until backing memory completes.
// - StallM feeds the hazard unit, which freezes IF/ID/EX/MEM while it is asserted.

---
 rtl/dcache_pkg.sv | 22 ++
 rtl/dcache_if.sv | 30 +++
 rtl/dcache_array.sv | 44 ++++
 rtl/dcache.sv | 130 +++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared geometry and state encoding for the direct-mapped write-through data cache.
// Line geometry is fixed here so every file agrees on field widths.
package dcache_pkg;
  localparam int DATA_WIDTH     = 32;
  localparam int LINES          = 16;
  localparam int WORDS_PER_LINE = 4;
  localparam int OFFSET_W       = $clog2(WORDS_PER_LINE);
  localparam int INDEX_W        = $clog2(LINES);
  localparam int TAG_W          = DATA_WIDTH - 2 - OFFSET_W - INDEX_W;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, WDONE} dcache_state_t;

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
  } addr_fields_t;

  function automatic addr_fields_t split_addr(input logic [DATA_WIDTH-3:0] word_addr);
    return addr_fields_t'(word_addr);
  endfunction
endpackage

// File: rtl/dcache_if.sv
// Pipeline-side and backing-memory-side signals of the data cache.
// master = MEM stage plus backing memory, slave = the cache itself.
interface dcache_if;
  import dcache_pkg::*;

  logic                  ReadEnM;
  logic                  MemWriteM;
  logic [DATA_WIDTH-1:0] AddrM;
  logic [DATA_WIDTH-1:0] WriteDataM;
  logic [3:0]            ByteEnM;
  logic [DATA_WIDTH-1:0] ReadDataM;
  logic                  StallM;
  logic                  MemReq;
  logic                  MemWe;
  logic [DATA_WIDTH-1:0] MemAddr;
  logic [DATA_WIDTH-1:0] MemWData;
  logic [3:0]            MemBe;
  logic                  MemAck;
  logic [DATA_WIDTH-1:0] MemRData;

  modport master (
    output ReadEnM, MemWriteM, AddrM, WriteDataM, ByteEnM, MemAck, MemRData,
    input  ReadDataM, StallM, MemReq, MemWe, MemAddr, MemWData, MemBe
  );

  modport slave (
    input  ReadEnM, MemWriteM, AddrM, WriteDataM, ByteEnM, MemAck, MemRData,
    output ReadDataM, StallM, MemReq, MemWe, MemAddr, MemWData, MemBe
  );
endinterface

// File: rtl/dcache_array.sv
// Tag, valid and data storage: asynchronous read, byte-enabled synchronous write.
// Only the valid bits are reset; tags and data keep whatever they held.
module dcache_array
  import dcache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_W-1:0]    index_i,
  input  logic [OFFSET_W-1:0]   rd_offset_i,
  output logic                  rd_valid_o,
  output logic [TAG_W-1:0]      rd_tag_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  input  logic                  wr_en_i,
  input  logic [OFFSET_W-1:0]   wr_offset_i,
  input  logic [3:0]            wr_be_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  fill_i,
  input  logic [TAG_W-1:0]      fill_tag_i
);
  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [DATA_WIDTH-1:0] data_q [LINES][WORDS_PER_LINE];

  assign rd_valid_o = valid_q[index_i];
  assign rd_tag_o   = tag_q[index_i];
  assign rd_data_o  = data_q[index_i][rd_offset_i];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_i) begin
      valid_q[index_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be_i[b]) data_q[index_i][wr_offset_i][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
    if (fill_i) tag_q[index_i] <= fill_tag_i;
  end
endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// Holds the access FSM, the refill beat counter and the backing-memory request registers.
//
// state  | meaning
// IDLE   | serve load hits combinationally, launch refills and writes
// REFILL | fetch the line word by word, beat index in cnt_q
// WRITE  | write-through request outstanding, merge into cache on ack if hit
// WDONE  | single unstalled cycle so the store retires
module dcache
  import dcache_pkg::*;
(
  input logic      clk,
  input logic      rst,
  dcache_if.slave  bus
);
  localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(WORDS_PER_LINE - 1);

  dcache_state_t         state_q;
  logic [OFFSET_W-1:0]   cnt_q;
  logic [OFFSET_W-1:0]   cnt_d;
  logic                  req_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            be_q;

  addr_fields_t          fields;
  logic                  rd_valid;
  logic [TAG_W-1:0]      rd_tag;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  hit;
  logic                  ack;
  logic                  refill_wr;
  logic                  store_wr;
  logic                  stall;
  logic                  unused_addr;

  assign fields      = split_addr(bus.AddrM[DATA_WIDTH-1:2]);
  assign unused_addr = ^bus.AddrM[1:0];
  assign hit         = rd_valid && (rd_tag == fields.tag);
  assign ack         = bus.MemAck && req_q;
  assign cnt_d       = cnt_q + 1'b1;
  assign refill_wr   = (state_q == REFILL) && ack;
  assign store_wr    = (state_q == WRITE) && ack && hit;

  dcache_array u_array (
    .clk         (clk),
    .rst         (rst),
    .index_i     (fields.index),
    .rd_offset_i (fields.offset),
    .rd_valid_o  (rd_valid),
    .rd_tag_o    (rd_tag),
    .rd_data_o   (rd_data),
    .wr_en_i     (refill_wr || store_wr),
    .wr_offset_i (refill_wr ? cnt_q : fields.offset),
    .wr_be_i     (refill_wr ? 4'hF : bus.ByteEnM),
    .wr_data_i   (refill_wr ? bus.MemRData : bus.WriteDataM),
    .fill_i      (refill_wr && (cnt_q == LAST_BEAT)),
    .fill_tag_i  (fields.tag)
  );

  always_comb begin
    stall = 1'b0;
    case (state_q)
      IDLE:          stall = bus.MemWriteM || (bus.ReadEnM && !hit);
      REFILL, WRITE: stall = 1'b1;
      default:       stall = 1'b0;
    endcase
  end

  // Stores win over a simultaneous (illegal) load, so a load hit needs MemWriteM low.
  assign bus.ReadDataM = (!rst && state_q == IDLE && bus.ReadEnM && !bus.MemWriteM && hit)
                         ? rd_data : '0;
  assign bus.StallM    = stall && !rst;
  assign bus.MemReq    = req_q;
  assign bus.MemWe     = we_q;
  assign bus.MemAddr   = addr_q;
  assign bus.MemWData  = wdata_q;
  assign bus.MemBe     = be_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.MemWriteM) begin
            state_q <= WRITE;
            req_q   <= 1'b1;
            we_q    <= 1'b1;
            addr_q  <= {bus.AddrM[DATA_WIDTH-1:2], 2'b00};
            wdata_q <= bus.WriteDataM;
            be_q    <= bus.ByteEnM;
          end else if (bus.ReadEnM && !hit) begin
            state_q <= REFILL;
            cnt_q   <= '0;
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            be_q    <= 4'hF;
            addr_q  <= {fields.tag, fields.index, {OFFSET_W{1'b0}}, 2'b00};
          end
        end
        REFILL: begin
          if (ack) begin
            cnt_q <= cnt_d;
            if (cnt_q == LAST_BEAT) begin
              state_q <= IDLE;
              req_q   <= 1'b0;
            end else begin
              addr_q <= {fields.tag, fields.index, cnt_d, 2'b00};
            end
          end
        end
        WRITE: begin
          if (ack) begin
            state_q <= WDONE;
            req_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
